// File: rtl/packet_assembler.sv
// Double-buffered word-to-packet assembler with valid/ready output and legacy send pulse.
// Define PACKET_TIMEOUT_EN to flush idle partial packets (padded with PAD_WORD) after TIMEOUT_CYCLES.
module packet_assembler #(
  parameter int                    WORD_WIDTH     = 8,
  parameter int                    PACKET_WORDS   = 4,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [WORD_WIDTH-1:0] PAD_WORD       = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [WORD_WIDTH-1:0]              word,
  input  logic                               write,
  output logic [PACKET_WORDS*WORD_WIDTH-1:0] sys_packet,
  output logic                               packet_valid,
  input  logic                               packet_ready,
  output logic                               send,
  output logic [$clog2(PACKET_WORDS+1)-1:0]  packet_len,
  output logic [$clog2(PACKET_WORDS+1)-1:0]  fill_level,
  output logic                               overflow,
  input  logic                               clear_overflow
);
  localparam int LW = $clog2(PACKET_WORDS+1);

  typedef enum logic {FILLING, WAIT_HOLD} state_t;
  typedef logic [PACKET_WORDS-1:0][WORD_WIDTH-1:0] pkt_t;

  state_t        state_q, state_d;
  pkt_t          fill_q, fill_d;
  pkt_t          hold_q, hold_d;
  logic          valid_q, valid_d;
  logic          send_q, send_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d;
  logic          hold_free;
  logic          expire;

`ifdef PACKET_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is the idle edge that would bring the counter to TIMEOUT_CYCLES.
  assign expire = (state_q == FILLING) && !write && (lvl_q != '0) &&
                  (cnt_q == CW'(TIMEOUT_CYCLES-1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == FILLING) && !write && (lvl_q != '0) && !expire)
      cnt_d = cnt_q + CW'(1);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{PAD_WORD, TIMEOUT_CYCLES[0]};
  assign expire     = 1'b0;
`endif

  assign hold_free = !valid_q || packet_ready;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    send_d  = 1'b0;
    len_d   = len_q;
    lvl_d   = lvl_q;
    ovf_d   = ovf_q;
    if (clear_overflow) ovf_d = 1'b0;
    if (valid_q && packet_ready) valid_d = 1'b0;
    case (state_q)
      FILLING: begin
        if (write) begin
          for (int i = 0; i < PACKET_WORDS; i++)
            if (lvl_q == LW'(i)) fill_d[i] = word;
          if (lvl_q == LW'(PACKET_WORDS-1)) begin
            if (hold_free) begin
              hold_d  = fill_d;
              valid_d = 1'b1;
              send_d  = 1'b1;
              len_d   = LW'(PACKET_WORDS);
              lvl_d   = '0;
            end else begin
              lvl_d   = LW'(PACKET_WORDS);
              state_d = WAIT_HOLD;
            end
          end else begin
            lvl_d = lvl_q + LW'(1);
          end
        end else if (expire) begin
          // Partial flush: pad unwritten slots, keep the partial count as the length.
          for (int i = 0; i < PACKET_WORDS; i++)
            if (LW'(i) >= lvl_q) fill_d[i] = PAD_WORD;
          if (hold_free) begin
            hold_d  = fill_d;
            valid_d = 1'b1;
            send_d  = 1'b1;
            len_d   = lvl_q;
            lvl_d   = '0;
          end else begin
            state_d = WAIT_HOLD;
          end
        end
      end
      WAIT_HOLD: begin
        if (write) ovf_d = 1'b1;
        if (valid_q && packet_ready) begin
          hold_d  = fill_q;
          len_d   = lvl_q;
          valid_d = 1'b1;
          send_d  = 1'b1;
          lvl_d   = '0;
          state_d = FILLING;
        end
      end
      default: state_d = FILLING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILLING;
      fill_q  <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      send_q  <= 1'b0;
      len_q   <= LW'(PACKET_WORDS);
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef PACKET_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      send_q  <= send_d;
      len_q   <= len_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
`ifdef PACKET_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign sys_packet   = hold_q;
  assign packet_valid = valid_q;
  assign send         = send_q;
  assign packet_len   = len_q;
  assign fill_level   = lvl_q;
  assign overflow     = ovf_q;
endmodule
